// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor with borrow in and borrow out.
//
// A request made in IDLE latches the operands and the initial borrow. The block then
// spends WIDTH RUN cycles processing one bit per cycle, LSB first, and one DONE cycle.
// The difference and the final borrow are registered on the edge that enters DONE.
// They hold their value until the next completion.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - operation request, accepted only in IDLE
//   a, b   - minuend and subtrahend, sampled at accept
//   b_in   - initial borrow into the LSB, sampled at accept
//   busy   - high in RUN and DONE
//   done   - one-cycle completion pulse (DONE state)
//   d      - registered difference, modulo 2^WIDTH
//   b_out  - registered borrow out of the MSB (a < b + b_in, unsigned)
//   ovf    - registered signed overflow; present only when SERIAL_SUB_OVF_EN is defined
//
// Build option: define SERIAL_SUB_OVF_EN to add the ovf output and its logic.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             b_out
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q, b_q;     // operands, shifted right one bit per RUN cycle
  logic [WIDTH-1:0] dsh_q;        // partial difference, filled from the MSB end
  logic             bor_q;        // running borrow
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  logic accept;
  logic last_bit;
  logic diff_bit;
  logic bor_next;

  assign accept   = (state_q == StIdle) && start;
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));
  assign diff_bit = a_q[0] ^ b_q[0] ^ bor_q;
  assign bor_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bor_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StIdle:  busy = 1'b0;
      StRun:   busy = 1'b1;
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Serial datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      dsh_q  <= '0;
      bor_q  <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (accept) begin
      cnt_q <= '0;
      a_q   <= a;
      b_q   <= b;
      bor_q <= b_in;
    end else if (state_q == StRun) begin
      cnt_q <= cnt_q + CntW'(1);
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      bor_q <= bor_next;
      dsh_q <= {diff_bit, dsh_q[WIDTH-1:1]};
      if (last_bit) begin
        d_q    <= {diff_bit, dsh_q[WIDTH-1:1]};
        bout_q <= bor_next;
`ifdef SERIAL_SUB_OVF_EN
        // bor_q here is the borrow into the MSB
        ovf_q  <= bor_q ^ bor_next;
`endif
      end
    end
  end

  assign d     = d_q;
  assign b_out = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks;
  int failures;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .d     (d),
`ifdef SERIAL_SUB_OVF_EN
    .ovf   (ovf),
`endif
    .b_out (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h time=%0t", name, got, exp, $time);
    end
  endtask

  // Arithmetic reference for a - b - bin
  function automatic logic [W-1:0] ref_d(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bi);
    int r;
    r = int'(x) - int'(y) - int'(bi);
    return W'(r);
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic bi);
    return int'(x) < (int'(y) + int'(bi));
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic bi);
    int r;
    r = int'($signed(x)) - int'($signed(y)) - int'(bi);
    return (r < -(2 ** (W - 1))) || (r > (2 ** (W - 1)) - 1);
  endfunction

  // Behavioural model: operation in flight for W+1 cycles after accept, results visible
  // from the cycle in which done is expected.
  logic         m_busy;
  int           m_age;
  logic [W-1:0] m_pd, m_d;
  logic         m_pb, m_b;
  logic         m_po, m_o;
  int           m_dones;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_pd   <= '0;
      m_d    <= '0;
      m_pb   <= 1'b0;
      m_b    <= 1'b0;
      m_po   <= 1'b0;
      m_o    <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        m_age  <= 1;
        m_pd   <= ref_d(a, b, b_in);
        m_pb   <= ref_bout(a, b, b_in);
        m_po   <= ref_ovf(a, b, b_in);
      end
    end else begin
      m_age <= m_age + 1;
      if (m_age == W) begin
        m_d <= m_pd;
        m_b <= m_pb;
        m_o <= m_po;
      end
      if (m_age == W + 1) m_busy <= 1'b0;
    end
  end

  // Compare process: every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, m_busy);
      check("done", done, m_busy && (m_age == W + 1));
      check("d", d, m_d);
      check("b_out", b_out, m_b);
`ifdef SERIAL_SUB_OVF_EN
      check("ovf", ovf, m_o);
`endif
      if (done) m_dones++;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  // Start one operation, scramble operands during RUN, check literal result and latency
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi,
                       input logic [W-1:0] ed, input logic eb, input string name);
    int n;
    wait_idle();
    @(negedge clk);
    a = ta; b = tb; b_in = tbi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
    n = 1;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, W + 1);
    check({name, "_d"}, d, ed);
    check({name, "_bout"}, b_out, eb);
  endtask

  initial begin
    int dones0;
    checks   = 0;
    failures = 0;
    m_dones  = 0;
    start    = 1'b0;
    a        = 8'hA5;
    b        = 8'h3C;
    b_in     = 1'b1;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    // Asynchronous reset, no clock edge yet
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_d", d, 8'h00);
    check("rst_bout", b_out, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "sub_5_3");
    do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "sub_0_1");
    do_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, "sub_10_0f_bin");
`ifdef SERIAL_SUB_OVF_EN
    do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "ovf_80_01");
    check("ovf_80_01_ovf", ovf, 1'b1);
    do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "ovf_5_3");
    check("ovf_5_3_ovf", ovf, 1'b0);
`endif

    // Second request during RUN is ignored
    wait_idle();
    dones0 = m_dones;
    @(negedge clk);
    a = 8'h09; b = 8'h04; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 15; i++) @(negedge clk);
    check("ignore_d", d, 8'h05);
    check("ignore_dones", m_dones - dones0, 1);

    // Reset during RUN aborts without done
    dones0 = m_dones;
    @(negedge clk);
    a = 8'h33; b = 8'h11; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_d", d, 8'h00);
    check("abort_bout", b_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) @(negedge clk);
    check("abort_no_done", m_dones - dones0, 0);
    do_op(8'h07, 8'h02, 1'b0, 8'h05, 1'b0, "after_abort");

    // Start held high: back-to-back operations every W+2 cycles
    wait_idle();
    dones0 = m_dones;
    start = 1'b1;
    for (int i = 0; i < 5 * (W + 2); i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
    end
    start = 1'b0;
    check("b2b_dones", m_dones - dones0, 5);

    // Random traffic with random gaps and operand churn
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
      if ($urandom_range(0, 9) == 0) a = 8'h00;
      if ($urandom_range(0, 9) == 0) b = 8'hFF;
    end
    start = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
